// File: rtl/io_pwr_seq_ctrl_if.sv
// Purpose: groups the power-manager request, supply-good input and ring gating outputs of one VDDIO segment.
// Latency: none (wiring only).
// Backpressure: none; all signals are levels.
interface io_pwr_seq_ctrl_if;
    logic       pwr_en_i;
    logic       fault_clr_i;
    logic       vddio_good_i;
    logic       supply_en_o;
    logic       pad_hold_o;
    logic       oe_allow_o;
    logic       ready_o;
    logic       fault_o;
    logic [2:0] state_o;

    modport master (
        output pwr_en_i, fault_clr_i, vddio_good_i,
        input  supply_en_o, pad_hold_o, oe_allow_o, ready_o, fault_o, state_o
    );

    modport slave (
        input  pwr_en_i, fault_clr_i, vddio_good_i,
        output supply_en_o, pad_hold_o, oe_allow_o, ready_o, fault_o, state_o
    );
endinterface

// File: rtl/io_pwr_seq_ctrl.sv
// Purpose: sequences a VDDIO ring segment: supply on, qualify, settle, release hold/OE; safe teardown on off or loss.
// Latency: supply_en one edge after request; ON at E(2+DEBOUNCE+SETTLE_CYC) after supply-good is first captured.
// Backpressure: none; pwr_en_i is a level request and is ignored while draining until OFF is reached.
module io_pwr_seq_ctrl #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned SETTLE_CYC  = 1000,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned DRAIN_CYC   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    io_pwr_seq_ctrl_if.slave  pio
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [3:0]  DBNC_MAX    = 4'(DEBOUNCE);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYC - 1);

    logic [1:0]  sync_q;
    logic [3:0]  dbnc_cnt;
    logic        good_q;
    logic [15:0] cnt;
    state_t      state_q;
    state_t      state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            dbnc_cnt <= 4'd0;
        end else begin
            sync_q <= {sync_q[0], pio.vddio_good_i};
            if (!sync_q[1]) begin
                dbnc_cnt <= 4'd0;
            end else if (dbnc_cnt != DBNC_MAX) begin
                dbnc_cnt <= dbnc_cnt + 4'd1;
            end
        end
    end

    // Gating with the synchronized level lets a supply loss reach the FSM one
    // edge earlier than waiting for the counter clear to propagate.
    assign good_q = (dbnc_cnt == DBNC_MAX) && sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt     <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (pio.pwr_en_i) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (!pio.pwr_en_i)           state_d = ST_DRAIN;
                else if (good_q)             state_d = ST_SETTLE;
                else if (cnt == TIMEOUT_LAST) state_d = ST_FAULT;
            end
            ST_SETTLE: begin
                if (!good_q)                 state_d = ST_FAULT;
                else if (!pio.pwr_en_i)      state_d = ST_DRAIN;
                else if (cnt == SETTLE_LAST) state_d = ST_ON;
            end
            ST_ON: begin
                if (!good_q)            state_d = ST_FAULT;
                else if (!pio.pwr_en_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (pio.fault_clr_i && !pio.pwr_en_i) state_d = ST_OFF;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        pio.supply_en_o = 1'b0;
        pio.pad_hold_o  = 1'b1;
        pio.oe_allow_o  = 1'b0;
        pio.ready_o     = 1'b0;
        pio.fault_o     = 1'b0;
        pio.state_o     = state_q;
        case (state_q)
            ST_RAMP, ST_SETTLE, ST_DRAIN: pio.supply_en_o = 1'b1;
            ST_ON: begin
                pio.supply_en_o = 1'b1;
                pio.pad_hold_o  = 1'b0;
                pio.oe_allow_o  = 1'b1;
                pio.ready_o     = 1'b1;
            end
            ST_FAULT: pio.fault_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// Purpose: directed bring-up/teardown scenarios followed by random traffic, all checked against a behavioural model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none.
module tb_io_pwr_seq_ctrl;

    localparam int D  = 2;
    localparam int SC = 8;
    localparam int TO = 16;
    localparam int DR = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    io_pwr_seq_ctrl_if pio();

    io_pwr_seq_ctrl #(
        .DEBOUNCE(D), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .DRAIN_CYC(DR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pio   (pio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: state number, time spent in it, and the raw supply-good
    // samples (newest first). Qualified after edge k means the samples at
    // edges k-1 .. k-1-D were all high.
    int m_state;
    int m_cnt;
    bit m_qual;
    bit hist[$];

    function automatic void m_reset();
        m_state = 0;
        m_cnt   = 0;
        m_qual  = 1'b0;
        hist.delete();
    endfunction

    function automatic bit m_calc_qual();
        if (hist.size() < D + 2) return 1'b0;
        for (int i = 1; i <= D + 1; i++) begin
            if (!hist[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_edge();
        int nxt;
        bit q;
        bit pwr;
        q   = m_qual;
        pwr = pio.pwr_en_i;
        hist.push_front(pio.vddio_good_i);
        if (hist.size() > D + 2) void'(hist.pop_back());
        nxt = m_state;
        case (m_state)
            0: if (pwr) nxt = 1;
            1: if (!pwr) nxt = 4; else if (q) nxt = 2; else if (m_cnt == TO - 1) nxt = 5;
            2: if (!q) nxt = 5; else if (!pwr) nxt = 4; else if (m_cnt == SC - 1) nxt = 3;
            3: if (!q) nxt = 5; else if (!pwr) nxt = 4;
            4: if (m_cnt == DR - 1) nxt = 0;
            5: if (pio.fault_clr_i && !pwr) nxt = 0;
            default: nxt = 5;
        endcase
        m_cnt   = (nxt != m_state) ? 0 : ((m_cnt + 1) & 16'hFFFF);
        m_state = nxt;
        m_qual  = m_calc_qual();
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  16'(pio.state_o),     16'(m_state));
        chk({tag, ".supply"}, 16'(pio.supply_en_o), 16'(m_state inside {1, 2, 3, 4}));
        chk({tag, ".hold"},   16'(pio.pad_hold_o),  16'(m_state != 3));
        chk({tag, ".oe"},     16'(pio.oe_allow_o),  16'(m_state == 3));
        chk({tag, ".ready"},  16'(pio.ready_o),     16'(m_state == 3));
        chk({tag, ".fault"},  16'(pio.fault_o),     16'(m_state == 5));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
    endtask

    // Called 1 ns after an edge; releases well clear of the next rising edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit saw_settle;
        rst_n            = 1'b0;
        pio.pwr_en_i     = 1'b0;
        pio.fault_clr_i  = 1'b0;
        pio.vddio_good_i = 1'b0;
        m_reset();
        #12;
        chk("rst.state",  16'(pio.state_o),     16'd0);
        chk("rst.supply", 16'(pio.supply_en_o), 16'd0);
        chk("rst.hold",   16'(pio.pad_hold_o),  16'd1);
        chk("rst.oe",     16'(pio.oe_allow_o),  16'd0);
        chk("rst.ready",  16'(pio.ready_o),     16'd0);
        chk("rst.fault",  16'(pio.fault_o),     16'd0);
        rst_n = 1'b1;

        // Nominal bring-up: request at N, supply-good first captured at E0.
        step("idle");
        pio.pwr_en_i = 1'b1;
        step("req");
        chk("req.supply_en", 16'(pio.supply_en_o), 16'd1);
        chk("req.ramp",      16'(pio.state_o),     16'd1);
        pio.vddio_good_i = 1'b1;
        step("e0");
        for (int e = 1; e <= 2 + D + SC; e++) begin
            step("up");
            if (e == 1 + D)      chk("up.still_ramp", 16'(pio.state_o), 16'd1);
            if (e == 2 + D)      chk("up.settle",     16'(pio.state_o), 16'd2);
            if (e == 1 + D + SC) chk("up.pre_on",     16'(pio.state_o), 16'd2);
        end
        chk("up.on",    16'(pio.state_o),    16'd3);
        chk("up.ready", 16'(pio.ready_o),    16'd1);
        chk("up.oe",    16'(pio.oe_allow_o), 16'd1);
        chk("up.hold",  16'(pio.pad_hold_o), 16'd0);

        // Orderly power-down.
        pio.pwr_en_i = 1'b0;
        step("drain");
        chk("drain.oe",     16'(pio.oe_allow_o),  16'd0);
        chk("drain.hold",   16'(pio.pad_hold_o),  16'd1);
        chk("drain.supply", 16'(pio.supply_en_o), 16'd1);
        for (int i = 1; i < DR; i++) step("drain");
        chk("drain.last", 16'(pio.state_o), 16'd4);
        step("drain_end");
        chk("drain.off",    16'(pio.state_o),     16'd0);
        chk("drain.sup_off", 16'(pio.supply_en_o), 16'd0);

        // Timeout with supply-good held low, then sticky fault handling.
        pio.vddio_good_i = 1'b0;
        for (int i = 0; i < 4; i++) step("off");
        pio.pwr_en_i = 1'b1;
        step("to_req");
        for (int i = 1; i < TO; i++) step("to_ramp");
        chk("to.last_ramp", 16'(pio.state_o), 16'd1);
        step("to_fault");
        chk("to.fault",  16'(pio.fault_o),     16'd1);
        chk("to.supply", 16'(pio.supply_en_o), 16'd0);
        pio.fault_clr_i = 1'b1;
        for (int i = 0; i < 3; i++) step("to_hold");
        chk("to.sticky", 16'(pio.fault_o), 16'd1);
        pio.pwr_en_i = 1'b0;
        step("to_clr");
        chk("to.cleared", 16'(pio.state_o), 16'd0);
        pio.fault_clr_i = 1'b0;

        // Glitch shorter than the debounce window never qualifies.
        pio.pwr_en_i = 1'b1;
        step("gl_req");
        pio.vddio_good_i = 1'b1;
        step("gl_hi");
        pio.vddio_good_i = 1'b0;
        saw_settle = 1'b0;
        for (int i = 2; i <= TO; i++) begin
            step("gl");
            if (pio.state_o == 3'd2) saw_settle = 1'b1;
        end
        chk("gl.no_settle", 16'(saw_settle),  16'd0);
        chk("gl.timeout",   16'(pio.state_o), 16'd5);
        pio.pwr_en_i    = 1'b0;
        pio.fault_clr_i = 1'b1;
        step("gl_clr");
        pio.fault_clr_i = 1'b0;

        // Supply loss in ON coinciding at the FSM with the pwr_en drop.
        pio.pwr_en_i     = 1'b1;
        pio.vddio_good_i = 1'b1;
        for (int i = 0; i < 3 + D + SC; i++) step("sl_up");
        chk("sl.on", 16'(pio.state_o), 16'd3);
        pio.vddio_good_i = 1'b0;
        step("sl_l");
        step("sl_l1");
        pio.pwr_en_i = 1'b0;
        step("sl_l2");
        chk("sl.fault", 16'(pio.state_o), 16'd5);
        pio.fault_clr_i = 1'b1;
        step("sl_clr");
        pio.fault_clr_i = 1'b0;

        // Asynchronous reset in the middle of SETTLE.
        pio.pwr_en_i     = 1'b1;
        pio.vddio_good_i = 1'b1;
        for (int i = 0; i < D + 4; i++) step("rs_up");
        chk("rs.settle", 16'(pio.state_o), 16'd2);
        do_reset("rs_arst");
        chk("rs.supply", 16'(pio.supply_en_o), 16'd0);
        chk("rs.hold",   16'(pio.pad_hold_o),  16'd1);
        step("rs_restart");
        chk("rs.ramp", 16'(pio.state_o), 16'd1);
        for (int i = 0; i < 2 + D + SC; i++) step("rs_up2");
        chk("rs.on", 16'(pio.state_o), 16'd3);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) pio.pwr_en_i = ~pio.pwr_en_i;
            if ($urandom_range(11) == 0) pio.vddio_good_i = ~pio.vddio_good_i;
            pio.fault_clr_i = ($urandom_range(3) == 0);
            if ($urandom_range(499) == 0) do_reset("rnd_arst");
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
